// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: IO register offsets,
// RV32I load/store size codes and byte-lane helpers.
package dmem_pkg;

  localparam logic [5:0] SW_OFS          = 6'h00;
  localparam logic [5:0] LED_OFS         = 6'h04;
  localparam logic [5:0] MTIME_LO_OFS    = 6'h08;
  localparam logic [5:0] MTIME_HI_OFS    = 6'h0C;
  localparam logic [5:0] MTIMECMP_LO_OFS = 6'h10;
  localparam logic [5:0] MTIMECMP_HI_OFS = 6'h14;
  localparam logic [5:0] STATUS_OFS      = 6'h18;
  localparam logic [5:0] CTRL_OFS        = 6'h1C;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } funct3_e;

  // Store codes share encodings with the signed loads.
  localparam funct3_e SB = LB;
  localparam funct3_e SH = LH;
  localparam funct3_e SW = LW;

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] ofs);
    case (sz)
      2'b00:   return 4'b0001 << ofs;
      2'b01:   return ofs[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_repl(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] ofs);
    logic [31:0] s;
    s = w >> {ofs, 3'b000};
    case (f3)
      LB:      return {{24{s[7]}}, s[7:0]};
      LH:      return {{16{s[15]}}, s[15:0]};
      LBU:     return {24'b0, s[7:0]};
      LHU:     return {16'b0, s[15:0]};
      default: return s;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, cleared on reset.
module sync_2ff #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d, sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/data_memory_io.sv
// MEM-stage data memory: byte-addressable RAM plus a word-only IO window
// holding switches, LEDs, a 64-bit cycle timer and its compare interrupt.
module data_memory_io
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned SW_W        = 8,
  parameter int unsigned LED_W       = 8,
  parameter logic [31:0] IO_BASE     = 32'h0001_0000,
  parameter int unsigned TICK_DIV    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      addr,
  input  logic [31:0]      dataW,
  input  logic             MemEn,
  input  logic             MemRW,
  input  logic [2:0]       funct3,
  output logic [31:0]      dataR,
  output logic             access_err,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led,
  output logic             timer_irq
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic [SW_W-1:0]  sw_sync;
  logic [LED_W-1:0] led_q, led_d;
  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      mtimecmp_q, mtimecmp_d;
  logic [31:0]      hi_snap_q, hi_snap_d;
  logic [31:0]      presc_q, presc_d;
  logic             irq_pending_q, irq_pending_d;
  logic             irq_en_q, irq_en_d;
  logic             timer_en_q, timer_en_d;

  logic [1:0]  sz;
  logic [5:0]  ofs;
  logic        f3_ok, align_ok, ram_hit, io_ok, legal, acc;
  logic        ram_we, io_we, io_re, tick;
  logic [3:0]  be;
  logic [31:0] wdata, ram_rdata, io_rdata;

  sync_2ff #(.W(SW_W)) u_sw_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sw),
    .q    (sw_sync)
  );

  // Decode: every access is either fully legal and takes effect, or flagged with no side effects.
  always_comb begin
    sz  = funct3[1:0];
    ofs = addr[5:0];
    if (MemRW) f3_ok = funct3 inside {SB, SH, SW};
    else       f3_ok = funct3 inside {LB, LH, LW, LBU, LHU};
    case (sz)
      2'b01:   align_ok = !addr[0];
      2'b10:   align_ok = (addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    ram_hit    = addr < RAM_BYTES;
    io_ok      = (addr[31:6] == IO_BASE[31:6]) && !addr[5] && (sz == 2'b10);
    legal      = f3_ok && align_ok && (ram_hit || io_ok);
    access_err = MemEn && !legal;
    // Gating with rst_n drops any write caught in flight by a reset.
    acc        = rst_n && MemEn && legal;
    ram_we     = acc && ram_hit && MemRW;
    io_we      = acc && !ram_hit && MemRW;
    io_re      = acc && !ram_hit && !MemRW;
    be         = byte_en(sz, addr[1:0]);
    wdata      = store_repl(dataW, sz);
  end

  always_ff @(posedge clk) begin
    if (ram_we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
  end

  assign ram_rdata = mem[addr[AW+1:2]];

  always_comb begin
    io_rdata = '0;
    case (ofs)
      SW_OFS:          io_rdata = 32'(sw_sync);
      LED_OFS:         io_rdata = 32'(led_q);
      MTIME_LO_OFS:    io_rdata = mtime_q[31:0];
      MTIME_HI_OFS:    io_rdata = hi_snap_q;
      MTIMECMP_LO_OFS: io_rdata = mtimecmp_q[31:0];
      MTIMECMP_HI_OFS: io_rdata = mtimecmp_q[63:32];
      STATUS_OFS:      io_rdata = {31'b0, irq_pending_q};
      CTRL_OFS:        io_rdata = {30'b0, timer_en_q, irq_en_q};
      default:         io_rdata = '0;
    endcase
    dataR = '0;
    if (acc && !MemRW) dataR = ram_hit ? load_ext(ram_rdata, funct3, addr[1:0]) : io_rdata;
  end

  always_comb begin
    led_d      = led_q;
    mtimecmp_d = mtimecmp_q;
    irq_en_d   = irq_en_q;
    timer_en_d = timer_en_q;
    hi_snap_d  = hi_snap_q;
    if (io_we) begin
      case (ofs)
        LED_OFS:         led_d = dataW[LED_W-1:0];
        MTIMECMP_LO_OFS: mtimecmp_d[31:0]  = dataW;
        MTIMECMP_HI_OFS: mtimecmp_d[63:32] = dataW;
        CTRL_OFS: begin
          irq_en_d   = dataW[0];
          timer_en_d = dataW[1];
        end
        default: ;
      endcase
    end
    // Snapshot the upper half so a following HI read matches this LO read.
    if (io_re && ofs == MTIME_LO_OFS) hi_snap_d = mtime_q[63:32];

    tick    = timer_en_q && (presc_q == 32'(TICK_DIV - 1));
    presc_d = presc_q;
    if (timer_en_q) presc_d = tick ? '0 : presc_q + 32'd1;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;

    // Set wins over a same-cycle W1C clear.
    irq_pending_d = irq_pending_q;
    if (io_we && ofs == STATUS_OFS && dataW[0]) irq_pending_d = 1'b0;
    if (mtime_q >= mtimecmp_q)                  irq_pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q         <= '0;
      mtime_q       <= '0;
      mtimecmp_q    <= '1;
      hi_snap_q     <= '0;
      presc_q       <= '0;
      irq_pending_q <= 1'b0;
      irq_en_q      <= 1'b0;
      timer_en_q    <= 1'b1;
    end else begin
      led_q         <= led_d;
      mtime_q       <= mtime_d;
      mtimecmp_q    <= mtimecmp_d;
      hi_snap_q     <= hi_snap_d;
      presc_q       <= presc_d;
      irq_pending_q <= irq_pending_d;
      irq_en_q      <= irq_en_d;
      timer_en_q    <= timer_en_d;
    end
  end

  assign led       = led_q;
  assign timer_irq = irq_pending_q & irq_en_q;

endmodule

// File: tb/tb_data_memory_io.sv
// Directed bench for data_memory_io: RAM sizes/extension, illegal accesses,
// switch/LED IO, tear-free timer reads, compare IRQ and reset behaviour.
module tb_data_memory_io;
  import dmem_pkg::*;

  localparam logic [31:0] IOB = 32'h0001_0000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] addr = '0, dataW = '0, dataR;
  logic        MemEn = 1'b0, MemRW = 1'b0, access_err, timer_irq;
  logic [2:0]  funct3 = 3'b010;
  logic [7:0]  sw = '0, led;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0, n_fail = 0;

  data_memory_io dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .dataW     (dataW),
    .MemEn     (MemEn),
    .MemRW     (MemRW),
    .funct3    (funct3),
    .dataR     (dataR),
    .access_err(access_err),
    .sw        (sw),
    .led       (led),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive one access just after a rising edge, compare at the falling edge.
  task automatic acc(input string tag, input logic rw, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_d, input logic exp_e);
    exp_t e;
    @(posedge clk); #1;
    MemEn = 1'b1; MemRW = rw; funct3 = f3; addr = a; dataW = d;
    e.tag = tag; e.data = exp_d; e.err = exp_e;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, "/dataR"}, dataR, e.data);
    check({e.tag, "/err"}, 32'(access_err), 32'(e.err));
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    @(posedge clk); #1;
    MemEn = 1'b1; MemRW = 1'b0; funct3 = LW; addr = a; dataW = '0;
    @(negedge clk);
    v = dataR;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      MemEn = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] lo, hi;
    logic        saw;

    // Reset values while rst_n is held low, with a load pending.
    MemEn = 1'b1; MemRW = 1'b0; funct3 = LW; addr = 32'h100;
    #12;
    check("rst_dataR", dataR, 32'h0);
    check("rst_irq", 32'(timer_irq), 32'h0);
    check("rst_led", 32'(led), 32'h0);
    @(posedge clk); #1; rst_n = 1'b1; MemEn = 1'b0;

    acc("sw_rst",     0, LW, IOB + SW_OFS,          0, 32'h0,         0);
    acc("cmplo_rst",  0, LW, IOB + MTIMECMP_LO_OFS, 0, 32'hFFFF_FFFF, 0);
    acc("cmphi_rst",  0, LW, IOB + MTIMECMP_HI_OFS, 0, 32'hFFFF_FFFF, 0);
    acc("ctrl_rst",   0, LW, IOB + CTRL_OFS,        0, 32'h2,         0);
    acc("status_rst", 0, LW, IOB + STATUS_OFS,      0, 32'h0,         0);
    acc("st_ro_nop",  1, SW, IOB + MTIME_LO_OFS,    32'h1234, 32'h0,  0);

    // RAM sizes and extension.
    acc("sw_100",   1, SW,  32'h100, 32'h1122_3344, 32'h0, 0);
    acc("lb_103",   0, LB,  32'h103, 0, 32'h0000_0011, 0);
    acc("lbu_103",  0, LBU, 32'h103, 0, 32'h0000_0011, 0);
    acc("lh_102",   0, LH,  32'h102, 0, 32'h0000_1122, 0);
    acc("lhu_102",  0, LHU, 32'h102, 0, 32'h0000_1122, 0);
    acc("sb_101",   1, SB,  32'h101, 32'hFFFF_FF80, 32'h0, 0);
    acc("lb_101",   0, LB,  32'h101, 0, 32'hFFFF_FF80, 0);
    acc("lbu_101",  0, LBU, 32'h101, 0, 32'h0000_0080, 0);
    acc("lw_100",   0, LW,  32'h100, 0, 32'h1122_8044, 0);
    acc("sh_106",   1, SH,  32'h106, 32'h0000_BEEF, 32'h0, 0);
    acc("lh_106",   0, LH,  32'h106, 0, 32'hFFFF_BEEF, 0);
    acc("lhu_106",  0, LHU, 32'h106, 0, 32'h0000_BEEF, 0);

    // Illegal accesses: flagged, read zero, no side effects.
    acc("ill_lh_101",  0, LH,     32'h101,       0, 32'h0, 1);
    acc("ill_sw_102",  1, SW,     32'h102,       32'hDEAD_BEEF, 32'h0, 1);
    acc("ill_lw_end",  0, LW,     32'h1000,      0, 32'h0, 1);
    acc("ill_sb_io",   1, SB,     IOB + LED_OFS, 32'h33, 32'h0, 1);
    acc("ill_f3_011",  0, 3'b011, 32'h100,       0, 32'h0, 1);
    acc("ill_io_hole", 0, LW,     IOB + 32'h20,  0, 32'h0, 1);
    acc("reread_100",  0, LW,     32'h100,       0, 32'h1122_8044, 0);
    acc("led_unchg",   0, LW,     IOB + LED_OFS, 0, 32'h0, 0);

    // Switch synchroniser latency, LED width truncation.
    @(posedge clk); #1; sw = 8'hA5; MemEn = 1'b0;
    acc("sw_n1",   0, LW, IOB + SW_OFS,  0, 32'h0,  0);
    acc("sw_n2",   0, LW, IOB + SW_OFS,  0, 32'hA5, 0);
    acc("led_wr",  1, SW, IOB + LED_OFS, 32'h1FF, 32'h0, 0);
    acc("led_rd",  0, LW, IOB + LED_OFS, 0, 32'hFF, 0);
    check("led_pin", 32'(led), 32'hFF);

    // Compare interrupt: freeze, zero mtime, arm at 20, then run.
    acc("ctrl_off", 1, SW, IOB + CTRL_OFS, 32'h0, 32'h0, 0);
    idle(1);
    @(negedge clk); force dut.mtime_q = 64'd0;
    @(negedge clk); release dut.mtime_q;
    acc("frozen0", 0, LW, IOB + MTIME_LO_OFS, 0, 32'h0, 0);
    acc("cmplo20", 1, SW, IOB + MTIMECMP_LO_OFS, 32'd20, 32'h0, 0);
    acc("cmphi0",  1, SW, IOB + MTIMECMP_HI_OFS, 32'd0,  32'h0, 0);
    acc("ctrl_on", 1, SW, IOB + CTRL_OFS, 32'h3, 32'h0, 0);
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      rd(IOB + MTIME_LO_OFS, lo);
      check("irq_vs_mtime", 32'(timer_irq), 32'(lo > 32'd20));
      if (timer_irq) saw = 1'b1;
    end
    check("irq_rose", 32'(saw), 32'h1);
    acc("w1c_held", 1, SW, IOB + STATUS_OFS, 32'h1, 32'h0, 0);
    check("w1c_held_irq", 32'(timer_irq), 32'h1);
    acc("status_set", 0, LW, IOB + STATUS_OFS, 0, 32'h1, 0);
    acc("cmplo1000",  1, SW, IOB + MTIMECMP_LO_OFS, 32'd1000, 32'h0, 0);
    acc("w1c_clear",  1, SW, IOB + STATUS_OFS, 32'h1, 32'h0, 0);
    acc("status_clr", 0, LW, IOB + STATUS_OFS, 0, 32'h0, 0);
    check("irq_cleared", 32'(timer_irq), 32'h0);

    // Tear-free LO/HI reads across the 32-bit carry.
    acc("ctrl_frz", 1, SW, IOB + CTRL_OFS, 32'h1, 32'h0, 0);
    idle(1);
    @(negedge clk); force dut.mtime_q = 64'h0000_0000_FFFF_FFF0;
    @(negedge clk); release dut.mtime_q;
    acc("hold_lo1", 0, LW, IOB + MTIME_LO_OFS, 0, 32'hFFFF_FFF0, 0);
    idle(3);
    acc("hold_lo2", 0, LW, IOB + MTIME_LO_OFS, 0, 32'hFFFF_FFF0, 0);
    acc("hold_hi",  0, LW, IOB + MTIME_HI_OFS, 0, 32'h0, 0);
    acc("ctrl_run", 1, SW, IOB + CTRL_OFS, 32'h3, 32'h0, 0);
    hi = '0;
    for (int i = 0; i < 16; i++) begin
      rd(IOB + MTIME_LO_OFS, lo);
      rd(IOB + MTIME_HI_OFS, hi);
      check("tear_hi", hi, lo[31] ? 32'h0 : 32'h1);
    end
    check("carry_crossed", hi, 32'h1);
    check("irq_big_mtime", 32'(timer_irq), 32'h1);

    // Reset in the middle of an LED store and a running timer.
    @(posedge clk); #1;
    MemEn = 1'b1; MemRW = 1'b1; funct3 = SW; addr = IOB + LED_OFS; dataW = 32'h5A;
    @(negedge clk); rst_n = 1'b0; #1;
    check("mid_rst_led", 32'(led), 32'h0);
    check("mid_rst_irq", 32'(timer_irq), 32'h0);
    check("mid_rst_mtime", dut.mtime_q[31:0], 32'h0);
    @(posedge clk); #1;
    check("mid_rst_drop", 32'(led), 32'h0);
    MemRW = 1'b0; funct3 = LW; addr = 32'h100;
    #1;
    check("mid_rst_dataR", dataR, 32'h0);
    rst_n = 1'b1; MemEn = 1'b0;
    acc("post_rst_lo",  0, LW, IOB + MTIME_LO_OFS, 0, 32'h1, 0);
    acc("post_rst_ram", 0, LW, 32'h100, 0, 32'h1122_8044, 0);
    acc("post_rst_led", 0, LW, IOB + LED_OFS, 0, 32'h0, 0);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
